// File: rtl/shifter_pkg.sv
// Shared types for the pipelined ARM shifter: shift ops, decoded result kinds,
// the per-stage control payload and the mux-level split helper.
package shifter_pkg;

    localparam int unsigned AMT_WIDTH  = 8;
    // Enough amount bits for the widest supported datapath (128 -> 7 levels).
    localparam int unsigned MAX_LEVELS = 7;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    // How the final stage forms the result once the mux levels are done.
    typedef enum logic [2:0] {
        NORMAL = 3'd0,
        ZERO   = 3'd1,
        FILL   = 3'd2,
        PASS   = 3'd3,
        RRX    = 3'd4
    } sh_kind_e;

    // Control payload travelling alongside the data word.
    typedef struct packed {
        sh_kind_e               kind;
        sh_op_e                 op;
        logic                   fill;   // ASR sign / RRX carry-in / FILL value
        logic                   carry;  // carry-out, fully resolved at decode
        logic [MAX_LEVELS-1:0]  amt;    // effective amount, zero unless NORMAL
    } shCtrl_t;

    // First mux level owned by stage k; later stages absorb the remainder.
    function automatic int unsigned levelLo(input int unsigned k,
                                            input int unsigned levels,
                                            input int unsigned stages);
        int unsigned base;
        int unsigned extra;
        int unsigned lo;
        base  = levels / stages;
        extra = levels % stages;
        lo    = k * base;
        if (k > stages - extra) begin
            lo = lo + (k - (stages - extra));
        end
        return lo;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shifter: mux levels [LO, HI) plus valid/data
// registers. The LAST stage also forms the final result from the decoded kind.
// Ports: clk/rst_n; flush clears valid; advance loads the stage; prev* is the
// upstream payload; *Q are the registered outputs.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 1,
    parameter bit          LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             advance,
    input  logic             prevValid,
    input  shCtrl_t          prevCtrl,
    input  logic [WIDTH-1:0] prevData,
    output logic             validQ,
    output shCtrl_t          ctrlQ,
    output logic [WIDTH-1:0] dataQ
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result;

    // Barrel levels owned by this stage; level lvl moves by 2**lvl.
    always_comb begin
        shifted = prevData;
        for (int unsigned lvl = LO; lvl < HI; lvl++) begin
            if (prevCtrl.amt[3'(lvl)]) begin
                case (prevCtrl.op)
                    SH_LSL: shifted = shifted << (1 << lvl);
                    SH_LSR: shifted = shifted >> (1 << lvl);
                    SH_ASR: shifted = (shifted >> (1 << lvl))
                                    | ({WIDTH{prevCtrl.fill}} & ~({WIDTH{1'b1}} >> (1 << lvl)));
                    SH_ROR: shifted = (shifted >> (1 << lvl))
                                    | (shifted << (WIDTH - (1 << lvl)));
                    default: ;
                endcase
            end
        end
    end

    // Special-case kinds carry amount 0, so shifted is still the operand here.
    always_comb begin
        result = shifted;
        if (LAST) begin
            case (prevCtrl.kind)
                ZERO:    result = '0;
                FILL:    result = {WIDTH{prevCtrl.fill}};
                RRX:     result = {prevCtrl.fill, shifted[WIDTH-1:1]};
                default: ;
            endcase
        end
    end

    // Stage registers; data only loads with a valid op so stalled outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ <= 1'b0;
            ctrlQ  <= '0;
            dataQ  <= '0;
        end else begin
            if (flush) begin
                validQ <= 1'b0;
            end else if (advance) begin
                validQ <= prevValid;
            end
            if (advance && prevValid) begin
                ctrlQ <= prevCtrl;
                dataQ <= result;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined ARM data-processing shifter (LSL/LSR/ASR/ROR/RRX, immediate and
// register amounts) with valid/ready handshake and STAGES register stages.
// Ports: CLK/RESETn; flush; in_valid/in_ready with Sh, ShImm, ShAmt, ShIn,
// current_CFlag; out_valid/out_ready with ShOut, Shifter_carryOut.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           Sh,
    input  logic                 ShImm,
    input  logic [AMT_WIDTH-1:0] ShAmt,
    input  logic [WIDTH-1:0]     ShIn,
    input  logic                 current_CFlag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     ShOut,
    output logic                 Shifter_carryOut
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam logic [AMT_WIDTH:0] W_AMT = (AMT_WIDTH+1)'(WIDTH);

    logic [STAGES:0]  vld;
    shCtrl_t          ctrl [STAGES+1];
    logic [WIDTH-1:0] data [STAGES+1];
    logic [STAGES-1:0] adv;
    logic             readyEn;

    logic [LW-1:0]    n;
    logic [LW-1:0]    negN;
    logic [LW-1:0]    nMinus1;
    logic             carryNormal;
    logic [AMT_WIDTH:0] amtExt;
    shCtrl_t          dec;
    logic [$bits(shCtrl_t)-2:0] unusedCtrl;

    // Hold in_ready low until the first edge after reset release.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            readyEn <= 1'b0;
        end else begin
            readyEn <= 1'b1;
        end
    end

    assign in_ready = readyEn & adv[0];

    assign n       = ShAmt[LW-1:0];
    assign negN    = LW'(0) - n;
    assign nMinus1 = n - LW'(1);
    assign amtExt  = {1'b0, ShAmt};
    // Every in-range amount (imm n, reg a<W, ROR a mod W) equals n here.
    assign carryNormal = (Sh == SH_LSL) ? ShIn[negN] : ShIn[nMinus1];

    // Classify the operation; carry-out is fully resolved here.
    always_comb begin
        dec       = '0;
        dec.op    = sh_op_e'(Sh);
        dec.kind  = PASS;
        dec.fill  = ShIn[WIDTH-1];
        dec.carry = current_CFlag;
        if (ShImm) begin
            if (n != '0) begin
                dec.kind  = NORMAL;
                dec.carry = carryNormal;
            end else begin
                case (dec.op)
                    SH_LSL: dec.kind = PASS;
                    SH_LSR: begin dec.kind = ZERO; dec.carry = ShIn[WIDTH-1]; end
                    SH_ASR: begin dec.kind = FILL; dec.carry = ShIn[WIDTH-1]; end
                    SH_ROR: begin
                        dec.kind  = RRX;
                        dec.fill  = current_CFlag;
                        dec.carry = ShIn[0];
                    end
                    default: ;
                endcase
            end
        end else if (ShAmt != '0) begin
            if (amtExt < W_AMT) begin
                dec.kind  = NORMAL;
                dec.carry = carryNormal;
            end else begin
                case (dec.op)
                    SH_LSL: begin
                        dec.kind  = ZERO;
                        dec.carry = (amtExt == W_AMT) ? ShIn[0] : 1'b0;
                    end
                    SH_LSR: begin
                        dec.kind  = ZERO;
                        dec.carry = (amtExt == W_AMT) ? ShIn[WIDTH-1] : 1'b0;
                    end
                    SH_ASR: begin dec.kind = FILL; dec.carry = ShIn[WIDTH-1]; end
                    SH_ROR: begin
                        if (n != '0) begin
                            dec.kind  = NORMAL;
                            dec.carry = carryNormal;
                        end else begin
                            dec.kind  = PASS;
                            dec.carry = ShIn[WIDTH-1];
                        end
                    end
                    default: ;
                endcase
            end
        end
        dec.amt = (dec.kind == NORMAL) ? MAX_LEVELS'(n) : '0;
    end

    assign vld[0]  = in_valid & in_ready;
    assign ctrl[0] = dec;
    assign data[0] = ShIn;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage k moves when any downstream slot is free or the consumer takes.
        assign adv[k] = out_ready | ~(&vld[STAGES:k+1]);

        shift_stage #(
            .WIDTH (WIDTH),
            .LO    (levelLo(k, LW, STAGES)),
            .HI    (levelLo(k + 1, LW, STAGES)),
            .LAST  (k == STAGES - 1)
        ) uStage (
            .clk       (CLK),
            .rst_n     (RESETn),
            .flush     (flush),
            .advance   (adv[k]),
            .prevValid (vld[k]),
            .prevCtrl  (ctrl[k]),
            .prevData  (data[k]),
            .validQ    (vld[k+1]),
            .ctrlQ     (ctrl[k+1]),
            .dataQ     (data[k+1])
        );
    end

    assign out_valid        = vld[STAGES];
    assign ShOut            = data[STAGES];
    assign Shifter_carryOut = ctrl[STAGES].carry;
    assign unusedCtrl       = {ctrl[STAGES].kind, ctrl[STAGES].op,
                               ctrl[STAGES].fill, ctrl[STAGES].amt};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench: three 32-bit shifters (STAGES 2,1,3) share stimulus, plus a
// 64-bit STAGES=2 instance; table vectors then handshake/flush/reset sequences.
module tb_pipelined_shifter;

    typedef struct {
        logic [1:0]  sh;
        logic        imm;
        logic [7:0]  amt;
        logic [63:0] din;
        logic        c;
        logic [63:0] dout;
        logic        cout;
        string       name;
    } vec_t;

    localparam int unsigned STG [3] = '{2, 1, 3};

    logic        CLK;
    logic        RESETn;
    logic        flush;
    logic [1:0]  sh;
    logic        shImm;
    logic [7:0]  shAmt;
    logic        cFlag;
    logic [31:0] shIn32;
    logic [63:0] shIn64;
    logic [2:0]  inValid;
    logic [2:0]  outReady;
    logic [2:0]  inReady;
    logic [2:0]  outValid;
    logic [2:0]  carry;
    logic [31:0] shOut [3];
    logic        inValid64, outReady64, inReady64, outValid64, carry64;
    logic [63:0] shOut64;

    int nPass  = 0;
    int nTotal = 0;

    pipelined_shifter #(.WIDTH(32), .STAGES(2)) dutA (
        .CLK(CLK), .RESETn(RESETn), .flush(flush), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .Sh(sh), .ShImm(shImm), .ShAmt(shAmt), .ShIn(shIn32), .current_CFlag(cFlag),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .ShOut(shOut[0]), .Shifter_carryOut(carry[0]));

    pipelined_shifter #(.WIDTH(32), .STAGES(1)) dutB (
        .CLK(CLK), .RESETn(RESETn), .flush(flush), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .Sh(sh), .ShImm(shImm), .ShAmt(shAmt), .ShIn(shIn32), .current_CFlag(cFlag),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .ShOut(shOut[1]), .Shifter_carryOut(carry[1]));

    pipelined_shifter #(.WIDTH(32), .STAGES(3)) dutC (
        .CLK(CLK), .RESETn(RESETn), .flush(flush), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .Sh(sh), .ShImm(shImm), .ShAmt(shAmt), .ShIn(shIn32), .current_CFlag(cFlag),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .ShOut(shOut[2]), .Shifter_carryOut(carry[2]));

    pipelined_shifter #(.WIDTH(64), .STAGES(2)) dutW (
        .CLK(CLK), .RESETn(RESETn), .flush(flush), .in_valid(inValid64), .in_ready(inReady64),
        .Sh(sh), .ShImm(shImm), .ShAmt(shAmt), .ShIn(shIn64), .current_CFlag(cFlag),
        .out_valid(outValid64), .out_ready(outReady64), .ShOut(shOut64), .Shifter_carryOut(carry64));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic setOp(input vec_t v);
        sh = v.sh; shImm = v.imm; shAmt = v.amt; cFlag = v.c;
        shIn32 = v.din[31:0]; shIn64 = v.din;
    endtask

    // One op with out_ready high; checks ready, exact latency, data and carry.
    task automatic runVec(input vec_t v, input bit is64);
        @(negedge CLK);
        setOp(v);
        outReady = 3'b111; outReady64 = 1'b1;
        if (is64) inValid64 = 1'b1; else inValid = 3'b111;
        #1;
        if (is64) check({v.name, " ready64"}, 64'(inReady64), 64'd1);
        else for (int k = 0; k < 3; k++) check($sformatf("%s ready s%0d", v.name, STG[k]), 64'(inReady[k]), 64'd1);
        @(posedge CLK); #1;
        inValid = 3'b000; inValid64 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (is64) begin
                check($sformatf("%s valid64 c%0d", v.name, c), 64'(outValid64), 64'(c == 1));
                if (c == 1) begin
                    check({v.name, " out64"}, shOut64, v.dout);
                    check({v.name, " carry64"}, 64'(carry64), 64'(v.cout));
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("%s valid s%0d c%0d", v.name, STG[k], c), 64'(outValid[k]), 64'(c == int'(STG[k]) - 1));
                    if (c == int'(STG[k]) - 1) begin
                        check($sformatf("%s out s%0d", v.name, STG[k]), 64'(shOut[k]), 64'(v.dout[31:0]));
                        check($sformatf("%s carry s%0d", v.name, STG[k]), 64'(carry[k]), 64'(v.cout));
                    end
                end
            end
        end
    endtask

    vec_t v32 [21];
    vec_t v64 [7];

    initial begin
        int acc, got;
        bit sawStall;
        logic [31:0] held;
        vec_t tmp;

        //                sh     imm   amt     din                     c     dout                    cout
        v32[0]  = '{2'b00, 1'b1, 8'd5,   64'h0A550000,         1'b0, 64'h4AA00000,         1'b1, "lsl_imm5"};
        v32[1]  = '{2'b01, 1'b1, 8'd4,   64'h00000A55,         1'b1, 64'h000000A5,         1'b0, "lsr_imm4"};
        v32[2]  = '{2'b11, 1'b1, 8'd0,   64'h00000003,         1'b1, 64'h80000001,         1'b1, "rrx"};
        v32[3]  = '{2'b00, 1'b0, 8'd32,  64'h00000001,         1'b0, 64'h00000000,         1'b1, "lsl_r32"};
        v32[4]  = '{2'b01, 1'b0, 8'd33,  64'hFFFFFFFF,         1'b1, 64'h00000000,         1'b0, "lsr_r33"};
        v32[5]  = '{2'b10, 1'b0, 8'd200, 64'h80000000,         1'b0, 64'hFFFFFFFF,         1'b1, "asr_r200"};
        v32[6]  = '{2'b11, 1'b0, 8'd40,  64'h80000001,         1'b1, 64'h01800000,         1'b0, "ror_r40"};
        v32[7]  = '{2'b01, 1'b0, 8'd0,   64'h12345678,         1'b1, 64'h12345678,         1'b1, "reg_amt0"};
        v32[8]  = '{2'b00, 1'b1, 8'h20,  64'hDEADBEEF,         1'b0, 64'hDEADBEEF,         1'b0, "lsl_imm0"};
        v32[9]  = '{2'b01, 1'b1, 8'd0,   64'h80000000,         1'b0, 64'h00000000,         1'b1, "lsr_imm0"};
        v32[10] = '{2'b10, 1'b1, 8'd0,   64'h7FFFFFFF,         1'b1, 64'h00000000,         1'b0, "asr_imm0"};
        v32[11] = '{2'b10, 1'b0, 8'd4,   64'h80000010,         1'b0, 64'hF8000001,         1'b0, "asr_r4"};
        v32[12] = '{2'b11, 1'b0, 8'd32,  64'h80000000,         1'b0, 64'h80000000,         1'b1, "ror_r32"};
        v32[13] = '{2'b00, 1'b0, 8'd33,  64'hFFFFFFFF,         1'b1, 64'h00000000,         1'b0, "lsl_r33"};
        v32[14] = '{2'b01, 1'b0, 8'd32,  64'h80000000,         1'b0, 64'h00000000,         1'b1, "lsr_r32"};
        v32[15] = '{2'b00, 1'b0, 8'd31,  64'h00000003,         1'b0, 64'h80000000,         1'b1, "lsl_r31"};
        v32[16] = '{2'b11, 1'b1, 8'd4,   64'h0000000F,         1'b0, 64'hF0000000,         1'b1, "ror_imm4"};
        v32[17] = '{2'b10, 1'b0, 8'd31,  64'h40000000,         1'b0, 64'h00000000,         1'b1, "asr_r31"};
        v32[18] = '{2'b11, 1'b0, 8'd1,   64'h00000001,         1'b0, 64'h80000000,         1'b1, "ror_r1"};
        v32[19] = '{2'b01, 1'b0, 8'd1,   64'h00000002,         1'b1, 64'h00000001,         1'b0, "lsr_r1"};
        v32[20] = '{2'b01, 1'b1, 8'hE4,  64'h000000F0,         1'b1, 64'h0000000F,         1'b0, "lsr_imm_hibits"};

        v64[0] = '{2'b00, 1'b1, 8'd4,   64'h0F00000000000000, 1'b0, 64'hF000000000000000, 1'b0, "w64_lsl_imm4"};
        v64[1] = '{2'b00, 1'b0, 8'd64,  64'h0000000000000001, 1'b0, 64'h0000000000000000, 1'b1, "w64_lsl_r64"};
        v64[2] = '{2'b11, 1'b0, 8'd72,  64'h00000000000000AB, 1'b0, 64'hAB00000000000000, 1'b1, "w64_ror_r72"};
        v64[3] = '{2'b11, 1'b1, 8'd0,   64'h0000000000000002, 1'b1, 64'h8000000000000001, 1'b0, "w64_rrx"};
        v64[4] = '{2'b10, 1'b0, 8'd63,  64'h8000000000000000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "w64_asr_r63"};
        v64[5] = '{2'b01, 1'b1, 8'd32,  64'hFFFFFFFF00000000, 1'b0, 64'h00000000FFFFFFFF, 1'b0, "w64_lsr_imm32"};
        v64[6] = '{2'b10, 1'b1, 8'h40,  64'h8000000000000000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, "w64_asr_imm0"};

        RESETn = 1'b0; flush = 1'b0;
        inValid = '0; outReady = '0; inValid64 = 1'b0; outReady64 = 1'b0;
        sh = '0; shImm = 1'b0; shAmt = '0; cFlag = 1'b0; shIn32 = '0; shIn64 = '0;

        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst valid s%0d", STG[k]), 64'(outValid[k]), 64'd0);
            check($sformatf("rst out s%0d", STG[k]), 64'(shOut[k]), 64'd0);
            check($sformatf("rst carry s%0d", STG[k]), 64'(carry[k]), 64'd0);
        end
        check("rst valid64", 64'(outValid64), 64'd0);
        @(negedge CLK); RESETn = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 3; k++) check($sformatf("ready after rst s%0d", STG[k]), 64'(inReady[k]), 64'd1);

        foreach (v32[i]) runVec(v32[i], 1'b0);
        foreach (v64[i]) runVec(v64[i], 1'b1);

        // Back-pressure on the STAGES=2 instance: 6 ops, consumer stalls cycles 3..5
        acc = 0; got = 0; sawStall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge CLK);
            outReady[0] = !(cyc >= 3 && cyc <= 5);
            inValid[0]  = (acc < 6);
            sh = 2'b01; shImm = 1'b0; shAmt = 8'd4; cFlag = 1'b1;
            shIn32 = 32'((acc + 1) << 8);
            #1;
            if (inValid[0] && !inReady[0]) sawStall = 1'b1;
            if (cyc == 3) held = shOut[0];
            if (cyc == 4 || cyc == 5) begin
                check($sformatf("bp hold valid c%0d", cyc), 64'(outValid[0]), 64'd1);
                check($sformatf("bp hold data c%0d", cyc), 64'(shOut[0]), 64'(held));
            end
            if (outValid[0] && outReady[0]) begin
                check($sformatf("bp order %0d", got), 64'(shOut[0]), 64'(32'((got + 1) << 4)));
                check($sformatf("bp carry %0d", got), 64'(carry[0]), 64'd0);
                got++;
            end
            if (inValid[0] && inReady[0]) acc++;
        end
        check("bp in_ready fell", 64'(sawStall), 64'd1);
        check("bp result count", 64'(got), 64'd6);
        @(negedge CLK); inValid = '0; outReady = '1;
        #1; check("bp drained", 64'(outValid[0]), 64'd0);

        // Flush with ops in flight and a new op presented in the flush cycle
        tmp = v32[0];
        @(negedge CLK); setOp(tmp); inValid = 3'b111; outReady = 3'b000;
        @(negedge CLK); tmp = v32[6]; setOp(tmp);
        @(negedge CLK);
        check("pre-flush valid s2", 64'(outValid[0]), 64'd1);
        flush = 1'b1; tmp = v32[5]; setOp(tmp);
        @(posedge CLK); #1;
        flush = 1'b0; inValid = 3'b000; outReady = 3'b111;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) check($sformatf("flush empty s%0d c%0d", STG[k], c), 64'(outValid[k]), 64'd0);
        end
        runVec(v32[11], 1'b0);

        // Asynchronous reset mid-stream while results are held
        tmp = v32[18];
        @(negedge CLK); setOp(tmp); inValid = 3'b111; inValid64 = 1'b1; outReady = 3'b000; outReady64 = 1'b0;
        @(posedge CLK); #1; inValid = 3'b000; inValid64 = 1'b0;
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 3; k++) check($sformatf("pre-rst valid s%0d", STG[k]), 64'(outValid[k]), 64'd1);
        check("pre-rst valid64", 64'(outValid64), 64'd1);
        #2 RESETn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async rst valid s%0d", STG[k]), 64'(outValid[k]), 64'd0);
            check($sformatf("async rst out s%0d", STG[k]), 64'(shOut[k]), 64'd0);
        end
        check("async rst valid64", 64'(outValid64), 64'd0);
        check("async rst out64", shOut64, 64'd0);
        #3 RESETn = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 3; k++) check($sformatf("ready after rst2 s%0d", STG[k]), 64'(inReady[k]), 64'd1);
        check("ready after rst2 w64", 64'(inReady64), 64'd1);
        runVec(v32[2], 1'b0);
        runVec(v64[2], 1'b1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
